instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  Fetch stage upstream of the main control decoder. Holds the PC and issues
//  word reads to instruction memory over a req/ack handshake. Presents each
//  fetched instruction, plus PC+4, to decode through a valid/ready register
//  slice. id_opcode (instr[31:26]) drives the control unit's Instruction input.
//  Branch redirect flushes the slice and discards any in-flight fetch.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC after reset; bits [1:0] must be 0
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address (= pc); stable while imem_req=1
//  imem_ack       in   1   1-cycle pulse; imem_rdata valid this cycle
//  imem_rdata     in   32  instruction word
//  branch_taken   in   1   1-cycle redirect pulse
//  branch_target  in   32  redirect address; bits [1:0] ignored (forced 0)
//  id_valid       out  1   id_* outputs hold a valid instruction
//  id_ready       in   1   decode accepts when id_valid & id_ready
//  id_instr       out  32  fetched instruction
//  id_pc4         out  32  address of id_instr + 4
//  id_opcode      out  6   id_instr[31:26], to control unit
//  id_funct       out  6   id_instr[5:0], to ALU control
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, imem_req=0.
//   id_valid=0. id_instr, id_pc4, id_opcode and id_funct = 0.
//   Any in-flight fetch is abandoned; memory tolerates imem_req dropping.
//  All id_* outputs and imem_req are registered. id_opcode and id_funct are wires off id_instr.
//  FSM states: IDLE, FETCH, FULL, DROP.
//   IDLE : imem_req=0. Next cycle -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack:
//          id_instr<=rdata; id_pc4<=pc+4; id_valid<=1; pc<=pc+4.
//          Stay FETCH if slot free this cycle (!id_valid | id_ready), else -> FULL.
//          imem_ack may arrive in the first cycle of a request.
//   FULL : imem_req=0, id_valid=1. On id_ready: id_valid<=0 -> FETCH.
//   DROP : imem_req=1 with the old address. On imem_ack: rdata discarded -> FETCH.
//  Throughput: 1 instr/cycle with a 0-wait memory and id_ready held 1.
//  Latency: imem_ack to id_valid is 1 cycle.
//  Handshake: id_instr and id_pc4 are stable while id_valid & !id_ready.
//  Redirect has priority over imem_ack and id_ready in every state.
//   On branch_taken:
//   - pc<=branch_target & ~3; id_valid<=0 (a slot being accepted is still lost).
//   - FETCH with no ack this cycle -> DROP.
//   - FETCH with ack this cycle -> data discarded -> FETCH.
//   - IDLE, FULL or DROP -> FETCH (DROP: target request issues after the pending ack).
//  Wrap: pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0); id_pc4 wraps likewise.
//  Simultaneous events:
//   - ack + id_ready with a full slot: slot is replaced and id_valid stays 1.
//   - redirect in DROP: newest target wins; still waiting for the pending ack.
// TESTING
//  1 Reset, ack every cycle, id_ready=1 -> imem_addr 0,4,8,...; id_pc4 4,8,12, valid each cycle.
//  2 id_ready=0 after first instr (0x0000_0020 at addr 0) -> FULL, req=0, id_instr held; ready=1 -> fetch at 4.
//  3 branch_taken, target 0x40, while FETCH waits 3 cycles for ack -> DROP, late data dropped, next imem_addr=0x40.
//  4 branch_taken with ack same cycle, target 0x103 -> data dropped, id_valid=0, next imem_addr=0x100.
//  5 RESET_PC=32'hFFFF_FFFC, one fetch -> id_pc4=0, next imem_addr=0.
//  6 rst_n low mid-FETCH -> imem_req and id_valid 0 immediately; after release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : word-aligned fetch address, stable while imem_req=1
//   imem_ack   : one-cycle pulse, imem_rdata valid in the same cycle
//   imem_rdata : instruction word
// master: fetch stage side; slave: memory side.
interface instruction_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: holds the PC, issues word reads over the imem req/ack bus and presents each
// fetched instruction plus PC+4 to decode through a one-entry valid/ready slot.
// A taken branch flushes the slot and discards any in-flight fetch.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   imem                  : fetch bus (master modport)
//   branch_taken/target   : one-cycle redirect pulse and target (bits [1:0] forced to 0)
//   id_valid / id_ready   : decode handshake
//   id_instr, id_pc4      : fetched instruction and its address + 4
//   id_opcode, id_funct   : id_instr[31:26] and id_instr[5:0]
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    instruction_fetch_stage_if.master         imem,
    input  logic                              branch_taken,
    input  logic [31:0]                       branch_target,
    output logic                              id_valid,
    input  logic                              id_ready,
    output logic [31:0]                       id_instr,
    output logic [31:0]                       id_pc4,
    output logic [5:0]                        id_opcode,
    output logic [5:0]                        id_funct
);

    typedef enum logic [1:0] {StIdle, StFetch, StFull, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    logic [31:0] target_w;
    logic [31:0] pc_inc;
    logic        slot_free;

    assign target_w  = branch_target & ~32'd3;
    assign pc_inc    = pc_q + 32'd4;
    assign slot_free = !valid_q || id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;

        if (valid_q && id_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem.imem_ack) begin
                    if (slot_free) begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        // Slot still held: drop the word and refetch the same PC once drained.
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (id_ready) begin
                    state_d = StFetch;
                end
            end
            StDrop: begin
                if (imem.imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect overrides everything above.
        if (branch_taken) begin
            valid_d = 1'b0;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            tgt_d   = target_w;
            if ((state_q == StFetch || state_q == StDrop) && !imem.imem_ack) begin
                // Keep the outstanding address on the bus until its ack arrives.
                pc_d    = pc_q;
                state_d = StDrop;
            end else begin
                pc_d    = target_w;
                state_d = StFetch;
            end
        end
    end

    assign req_d = (state_d == StFetch) || (state_d == StDrop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign id_valid       = valid_q;
    assign id_instr       = instr_q;
    assign id_pc4         = pc4_q;
    assign id_opcode      = instr_q[31:26];
    assign id_funct       = instr_q[5:0];

endmodule
